spi_reg_bridge: RTL and testbench

//  SPI slave (mode 0: CPOL=0, CPHA=0) that sits directly upstream of the GPIO/register block.

---
 rtl/spi_reg_pkg.sv | 19 +
 rtl/spi_reg_bridge_if.sv | 25 ++
 rtl/spi_reg_bridge_sync_edge.sv | 32 +++
 rtl/spi_reg_bridge.sv | 176 +++++++++++++++++
 tb/tb_spi_reg_bridge.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/spi_reg_pkg.sv
// Shared constants, state encoding and command helpers for the SPI register bridge.
package spi_reg_pkg;

    localparam int CMD_RW_BIT = 7;
    localparam int FRAME_BITS = 16;
    localparam int CMD_BITS   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic is_write(input logic [7:0] cmd);
        return cmd[CMD_RW_BIT];
    endfunction

endpackage

// File: rtl/spi_reg_bridge_if.sv
// SPI pins plus the register-side bus; the bridge uses the slave view.
interface spi_reg_bridge_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              sclk;
    logic              cs_n;
    logic              mosi;
    logic              miso;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic [DATA_W-1:0] rdata;
    logic              abort;

    modport slave (
        input  sclk, cs_n, mosi, rdata,
        output miso, addr, wdata, we, abort
    );

    modport master (
        output sclk, cs_n, mosi, rdata,
        input  miso, addr, wdata, we, abort
    );
endinterface

// File: rtl/spi_reg_bridge_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, with rise/fall pulses of the synced level.
module sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);
    logic meta_q;
    logic sync_q;
    logic prev_q;

    // synchronizer chain plus one delayed copy for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;
endmodule

// File: rtl/spi_reg_bridge.sv
// Mode-0 SPI slave turning 16-bit frames {rw,3'b0,addr | data} into register write strobes
// and serving reads on miso; everything runs in clk, oversampling the SPI pins.
module spi_reg_bridge
    import spi_reg_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    spi_reg_bridge_if.slave   bus
);
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_CMD  = CMD;
    localparam logic [1:0] ST_DATA = DATA;
    localparam logic [1:0] ST_DONE = DONE;

    localparam logic [3:0] CMD_LAST   = 4'(CMD_BITS - 1);
    localparam logic [3:0] FRAME_LAST = 4'(FRAME_BITS - 1);

    logic sclk_rise_s, sclk_fall_s, sclk_lvl_unused;
    logic cs_sync_s, cs_rise_s, cs_fall_s;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .rst(rst), .d_i(bus.sclk),
        .sync_o(sclk_lvl_unused), .rise_o(sclk_rise_s), .fall_o(sclk_fall_s)
    );

    // cs_n idles high, so its synchronizer resets high to avoid a false frame start
    sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
        .clk(clk), .rst(rst), .d_i(bus.cs_n),
        .sync_o(cs_sync_s), .rise_o(cs_rise_s), .fall_o(cs_fall_s)
    );

    sync_edge #(.RST_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .rst(rst), .d_i(bus.mosi),
        .sync_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
    );

    logic [1:0]        state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              miso_q, miso_d;
    logic              abort_q, abort_d;
    logic [DATA_W-1:0] rx_shift_s;

    assign rx_shift_s = {rx_q[DATA_W-2:0], mosi_s};

    // frame FSM; on the last data bit the sclk rise wins over a simultaneous cs_n rise
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        miso_d    = miso_q;
        abort_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                miso_d    = 1'b0;
                bit_cnt_d = 4'd0;
                if (cs_fall_s) begin
                    state_d = ST_CMD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CMD: begin
                miso_d = 1'b0;
                if (cs_rise_s) begin
                    abort_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (sclk_rise_s) begin
                    rx_d      = rx_shift_s;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == CMD_LAST) begin
                        addr_d  = rx_shift_s[ADDR_W-1:0];
                        rw_d    = is_write(rx_shift_s);
                        tx_d    = bus.rdata;
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_CMD;
                    end
                end else begin
                    state_d = ST_CMD;
                end
            end
            ST_DATA: begin
                if (sclk_rise_s) begin
                    rx_d      = rx_shift_s;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == FRAME_LAST) begin
                        if (rw_q) begin
                            wdata_d = rx_shift_s;
                            we_d    = 1'b1;
                        end else begin
                            we_d    = 1'b0;
                        end
                        miso_d  = 1'b0;
                        state_d = cs_rise_s ? ST_IDLE : ST_DONE;
                    end else if (cs_rise_s) begin
                        abort_d = 1'b1;
                        miso_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else if (cs_rise_s) begin
                    abort_d = 1'b1;
                    miso_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (sclk_fall_s) begin
                    miso_d  = tx_q[DATA_W-1];
                    tx_d    = {tx_q[DATA_W-2:0], 1'b0};
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_DONE: begin
                miso_d = 1'b0;
                if (cs_sync_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                miso_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 4'd0;
            rx_q      <= '0;
            tx_q      <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            miso_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            miso_q    <= miso_d;
            abort_q   <= abort_d;
        end
    end

    assign bus.addr  = addr_q;
    assign bus.wdata = wdata_q;
    assign bus.we    = we_q;
    assign bus.miso  = miso_q;
    assign bus.abort = abort_q;
endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: write, read, abort, back-to-back, extra bits, mid-frame reset.
module tb_spi_reg_bridge;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    spi_reg_bridge_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    spi_reg_bridge #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // strobe monitor: counts pulses, records addr/wdata at each we, flags pulses wider than 1 clk
    int         we_cnt    = 0;
    int         abort_cnt = 0;
    int         we_wide   = 0;
    logic       we_prev   = 1'b0;
    logic [3:0] we_addr[$];
    logic [7:0] we_data[$];

    always @(negedge clk) begin
        if (bus.we === 1'b1) begin
            we_cnt <= we_cnt + 1;
            we_addr.push_back(bus.addr);
            we_data.push_back(bus.wdata);
            if (we_prev) we_wide <= we_wide + 1;
        end
        if (bus.abort === 1'b1) abort_cnt <= abort_cnt + 1;
        we_prev <= (bus.we === 1'b1);
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // drives nbits MSB-first from bits[23:..]; sclk half period is 4 clk; miso sampled before each rise
    task automatic spi_frame(input logic [23:0] bits, input int nbits, input logic [7:0] rd_late,
                             input bit end_cs, output logic [23:0] cap);
        cap = '0;
        bus.cs_n = 1'b0;
        wait_clk(4);
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = bits[23-i];
            wait_clk(4);
            cap = {cap[22:0], bus.miso};
            bus.sclk = 1'b1;
            if (i == 8) bus.rdata = rd_late;
            wait_clk(4);
            bus.sclk = 1'b0;
        end
        if (end_cs) begin
            wait_clk(4);
            bus.cs_n = 1'b1;
            bus.mosi = 1'b0;
            wait_clk(6);
        end
    endtask

    initial begin
        logic [23:0] cap;
        int          we0;
        int          ab0;
        int          q0;

        rst       = 1'b1;
        bus.sclk  = 1'b0;
        bus.cs_n  = 1'b1;
        bus.mosi  = 1'b0;
        bus.rdata = 8'h00;
        wait_clk(3);
        chk("rst_addr",  32'(bus.addr),  32'h0);
        chk("rst_wdata", 32'(bus.wdata), 32'h0);
        chk("rst_we",    32'(bus.we),    32'h0);
        chk("rst_miso",  32'(bus.miso),  32'h0);
        chk("rst_abort", 32'(bus.abort), 32'h0);
        rst = 1'b0;
        wait_clk(3);

        // write 0x83,0xA5
        we0 = we_cnt; ab0 = abort_cnt; q0 = we_addr.size();
        spi_frame({8'h83, 8'hA5, 8'h00}, 16, 8'h00, 1'b1, cap);
        chk("wr_we_cnt",  32'(we_cnt - we0),   32'd1);
        chk("wr_addr",    32'(we_addr[q0]),    32'h3);
        chk("wr_wdata",   32'(we_data[q0]),    32'hA5);
        chk("wr_miso",    32'(cap[15:0]),      32'h0);
        chk("wr_noabort", 32'(abort_cnt - ab0), 32'd0);

        // read with rdata=0x5C
        bus.rdata = 8'h5C;
        we0 = we_cnt;
        spi_frame({8'h02, 8'h00, 8'h00}, 16, 8'h5C, 1'b1, cap);
        chk("rd_we_cnt", 32'(we_cnt - we0), 32'd0);
        chk("rd_addr",   32'(bus.addr),     32'h2);
        chk("rd_miso",   32'(cap[15:0]),    32'h005C);
        chk("rd_wdata",  32'(bus.wdata),    32'hA5);

        // read where rdata changes after the latch point
        bus.rdata = 8'hC3;
        spi_frame({8'h05, 8'h00, 8'h00}, 16, 8'h00, 1'b1, cap);
        chk("rd2_addr", 32'(bus.addr),  32'h5);
        chk("rd2_miso", 32'(cap[15:0]), 32'h00C3);
        bus.rdata = 8'h00;

        // back-to-back writes with a 6-clk gap
        we0 = we_cnt; q0 = we_addr.size();
        spi_frame({8'h81, 8'h11, 8'h00}, 16, 8'h00, 1'b1, cap);
        spi_frame({8'h82, 8'h22, 8'h00}, 16, 8'h00, 1'b1, cap);
        chk("b2b_we_cnt", 32'(we_cnt - we0),     32'd2);
        chk("b2b_addr0",  32'(we_addr[q0]),      32'h1);
        chk("b2b_data0",  32'(we_data[q0]),      32'h11);
        chk("b2b_addr1",  32'(we_addr[q0 + 1]),  32'h2);
        chk("b2b_data1",  32'(we_data[q0 + 1]),  32'h22);

        // abort after 11 bits
        we0 = we_cnt; ab0 = abort_cnt;
        spi_frame({8'h81, 8'hFF, 8'h00}, 11, 8'h00, 1'b1, cap);
        chk("abt_pulse", 32'(abort_cnt - ab0), 32'd1);
        chk("abt_no_we", 32'(we_cnt - we0),    32'd0);
        chk("abt_wdata", 32'(bus.wdata),       32'h22);

        // 24 clocks: bits past the 16th are ignored
        we0 = we_cnt; ab0 = abort_cnt; q0 = we_addr.size();
        spi_frame({8'h84, 8'h3C, 8'hFF}, 24, 8'h00, 1'b1, cap);
        chk("ext_we_cnt", 32'(we_cnt - we0),    32'd1);
        chk("ext_addr",   32'(we_addr[q0]),     32'h4);
        chk("ext_wdata",  32'(we_data[q0]),     32'h3C);
        chk("ext_abort",  32'(abort_cnt - ab0), 32'd0);

        // reset during bit 12 of a write
        we0 = we_cnt;
        spi_frame({8'h85, 8'h77, 8'h00}, 12, 8'h00, 1'b0, cap);
        rst = 1'b1;
        #2;
        chk("mid_rst_addr",  32'(bus.addr),  32'h0);
        chk("mid_rst_wdata", 32'(bus.wdata), 32'h0);
        chk("mid_rst_we",    32'(bus.we),    32'h0);
        chk("mid_rst_miso",  32'(bus.miso),  32'h0);
        chk("mid_rst_abort", 32'(bus.abort), 32'h0);
        bus.cs_n = 1'b1;
        bus.sclk = 1'b0;
        bus.mosi = 1'b0;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(6);
        chk("mid_rst_lost", 32'(we_cnt - we0), 32'd0);

        q0 = we_addr.size();
        spi_frame({8'h86, 8'h99, 8'h00}, 16, 8'h00, 1'b1, cap);
        chk("post_rst_we_cnt", 32'(we_cnt - we0), 32'd1);
        chk("post_rst_addr",   32'(we_addr[q0]),  32'h6);
        chk("post_rst_wdata",  32'(we_data[q0]),  32'h99);

        chk("we_width", 32'(we_wide), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
